// File: rtl/bp_be_dcache_arbiter.sv
// D$ port arbiter between the backend pipe and the page-table walker.
// Pipe has priority in FREE unless the PTW has been deferred starve_limit_p
// cycles. The PTW can take exclusive ownership (FREE -> DRAIN -> LOCK).
// A two-stage owner record (mem1, mem2) routes the late tag and early hit
// back to whichever requester issued each op.
// Optional: define BP_BE_DCACHE_ARB_STATS_EN to add grant/conflict counters.
module bp_be_dcache_arbiter #(
    parameter int pkt_width_p    = 64,
    parameter int ptag_width_p   = 28,
    parameter int starve_limit_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    flush_i,
    input  logic                    pipe_v_i,
    input  logic                    ptw_v_i,
    input  logic [pkt_width_p-1:0]  pipe_pkt_i,
    input  logic [pkt_width_p-1:0]  ptw_pkt_i,
    input  logic [ptag_width_p-1:0] pipe_ptag_i,
    input  logic [ptag_width_p-1:0] ptw_ptag_i,
    input  logic                    pipe_ptag_v_i,
    input  logic                    ptw_ptag_v_i,
    output logic                    pipe_yumi_o,
    output logic                    ptw_yumi_o,
    input  logic                    ptw_lock_i,
    input  logic                    ptw_done_i,
    output logic                    ptw_lock_o,
    output logic                    dcache_v_o,
    output logic [pkt_width_p-1:0]  dcache_pkt_o,
    output logic [ptag_width_p-1:0] dcache_ptag_o,
    output logic                    dcache_ptag_v_o,
    input  logic                    dcache_ready_i,
    input  logic                    dcache_early_v_i,
    output logic                    pipe_early_v_o,
    output logic                    ptw_early_v_o
`ifdef BP_BE_DCACHE_ARB_STATS_EN
    ,
    output logic [31:0]             stat_pipe_grants_o,
    output logic [31:0]             stat_ptw_grants_o,
    output logic [31:0]             stat_conflict_o
`endif
);

    localparam int cnt_w_lp = $clog2(starve_limit_p + 1);

    typedef enum logic [1:0] {FREE, DRAIN, LOCK} state_e;

    state_e              state_r, state_n;
    logic [cnt_w_lp-1:0] starve_cnt_r;
    logic                starved;
    logic                pipe_cand, ptw_cand;
    logic                pipe_yumi, ptw_yumi;
    logic                mem_v_p1, mem_ptw_p1;
    logic                mem_v_p2, mem_ptw_p2;
    logic                mem1_live, mem2_live;
    logic                drained;

    function automatic logic [cnt_w_lp-1:0] sat_inc_starve(input logic [cnt_w_lp-1:0] v);
        return (v == cnt_w_lp'(starve_limit_p)) ? v : v + cnt_w_lp'(1);
    endfunction

    // Grant selection: pipe only when FREE, not flushed and no lock request pending
    always_comb begin
        starved   = (starve_cnt_r == cnt_w_lp'(starve_limit_p));
        pipe_cand = reset_n_i & pipe_v_i & dcache_ready_i & ~flush_i
                  & (state_r == FREE) & ~ptw_lock_i;
        ptw_cand  = reset_n_i & ptw_v_i & dcache_ready_i;
        pipe_yumi = pipe_cand & ~(ptw_cand & starved);
        ptw_yumi  = ptw_cand & ~pipe_yumi;
        // a flush kills pipe-owned ops in flight, PTW ops survive
        mem1_live = mem_v_p1 & (mem_ptw_p1 | ~flush_i);
        mem2_live = mem_v_p2 & (mem_ptw_p2 | ~flush_i);
        // after this edge no pipe op remains in mem1/mem2 (no new pipe grant is possible here)
        drained   = ~(mem1_live & ~mem_ptw_p1);
    end

    // Ownership FSM next state
    always_comb begin
        state_n = state_r;
        case (state_r)
            FREE:    if (ptw_lock_i) state_n = drained ? LOCK : DRAIN;
            DRAIN:   if (drained)    state_n = LOCK;
            LOCK:    if (ptw_done_i) state_n = FREE;
            default: state_n = FREE;
        endcase
    end

    // Ownership FSM state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= FREE;
        else            state_r <= state_n;
    end

    // PTW starvation counter: saturates at the limit, cleared on a PTW grant
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)   starve_cnt_r <= '0;
        else if (ptw_yumi) starve_cnt_r <= '0;
        else if (ptw_v_i)  starve_cnt_r <= sat_inc_starve(starve_cnt_r);
    end

    // Stage boundary: grant -> mem1 -> mem2 owner/valid record
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_v_p1   <= 1'b0;
            mem_ptw_p1 <= 1'b0;
            mem_v_p2   <= 1'b0;
            mem_ptw_p2 <= 1'b0;
        end else begin
            mem_v_p1   <= pipe_yumi | ptw_yumi;
            mem_ptw_p1 <= ptw_yumi;
            mem_v_p2   <= mem1_live;
            mem_ptw_p2 <= mem_ptw_p1;
        end
    end

    assign pipe_yumi_o     = pipe_yumi;
    assign ptw_yumi_o      = ptw_yumi;
    assign ptw_lock_o      = (state_r == LOCK);
    assign dcache_v_o      = pipe_yumi | ptw_yumi;
    assign dcache_pkt_o    = ptw_yumi ? ptw_pkt_i : pipe_pkt_i;
    assign dcache_ptag_o   = mem_ptw_p1 ? ptw_ptag_i : pipe_ptag_i;
    assign dcache_ptag_v_o = mem1_live & (mem_ptw_p1 ? ptw_ptag_v_i : pipe_ptag_v_i);
    assign ptw_early_v_o   = mem2_live &  mem_ptw_p2 & dcache_early_v_i;
    assign pipe_early_v_o  = mem2_live & ~mem_ptw_p2 & dcache_early_v_i;

`ifdef BP_BE_DCACHE_ARB_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating grant and contention counters
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stat_pipe_grants_o <= '0;
            stat_ptw_grants_o  <= '0;
            stat_conflict_o    <= '0;
        end else begin
            if (pipe_yumi)           stat_pipe_grants_o <= sat_inc32(stat_pipe_grants_o);
            if (ptw_yumi)            stat_ptw_grants_o  <= sat_inc32(stat_ptw_grants_o);
            if (pipe_v_i && ptw_v_i) stat_conflict_o    <= sat_inc32(stat_conflict_o);
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_dcache_arbiter.sv
// Directed testbench for bp_be_dcache_arbiter (default build, no stats).
module tb_bp_be_dcache_arbiter;

    localparam int PW = 64;
    localparam int TW = 28;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          pipe_v, ptw_v;
    logic [PW-1:0] pipe_pkt, ptw_pkt;
    logic [TW-1:0] pipe_ptag, ptw_ptag;
    logic          pipe_ptag_v, ptw_ptag_v;
    logic          pipe_yumi, ptw_yumi;
    logic          lock_i, done_i, lock_o;
    logic          dc_v;
    logic [PW-1:0] dc_pkt;
    logic [TW-1:0] dc_ptag;
    logic          dc_ptag_v;
    logic          ready, early;
    logic          pipe_early, ptw_early;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bp_be_dcache_arbiter #(.pkt_width_p(PW), .ptag_width_p(TW), .starve_limit_p(8)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
        .pipe_v_i(pipe_v), .ptw_v_i(ptw_v),
        .pipe_pkt_i(pipe_pkt), .ptw_pkt_i(ptw_pkt),
        .pipe_ptag_i(pipe_ptag), .ptw_ptag_i(ptw_ptag),
        .pipe_ptag_v_i(pipe_ptag_v), .ptw_ptag_v_i(ptw_ptag_v),
        .pipe_yumi_o(pipe_yumi), .ptw_yumi_o(ptw_yumi),
        .ptw_lock_i(lock_i), .ptw_done_i(done_i), .ptw_lock_o(lock_o),
        .dcache_v_o(dc_v), .dcache_pkt_o(dc_pkt), .dcache_ptag_o(dc_ptag),
        .dcache_ptag_v_o(dc_ptag_v), .dcache_ready_i(ready),
        .dcache_early_v_i(early),
        .pipe_early_v_o(pipe_early), .ptw_early_v_o(ptw_early)
    );

    task automatic clear_inputs();
        flush = 0; pipe_v = 0; ptw_v = 0; lock_i = 0; done_i = 0;
        ready = 1; early = 0; pipe_ptag_v = 0; ptw_ptag_v = 0;
        pipe_pkt = 64'hAAAA_0000_0000_0001; ptw_pkt = 64'h5555_0000_0000_0002;
        pipe_ptag = 28'h0AB_CDEF; ptw_ptag = 28'h123_4567;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_inputs();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0; pipe_v = 1; ptw_v = 1; lock_i = 1; early = 1; pipe_ptag_v = 1;
        #3;
        total++; if (pipe_yumi !== 1'b0) $display("FAIL rst_pipe_yumi got %b want 0", pipe_yumi); else passed++;
        total++; if (ptw_yumi  !== 1'b0) $display("FAIL rst_ptw_yumi got %b want 0", ptw_yumi); else passed++;
        total++; if (dc_v      !== 1'b0) $display("FAIL rst_dcache_v got %b want 0", dc_v); else passed++;
        repeat (2) @(negedge clk);
        #1;
        total++; if (lock_o !== 1'b0) $display("FAIL rst_lock_o got %b want 0", lock_o); else passed++;
        total++; if ({pipe_early, ptw_early, dc_ptag_v} !== 3'b000)
            $display("FAIL rst_early_ptag got %b want 000", {pipe_early, ptw_early, dc_ptag_v}); else passed++;
        @(negedge clk);
        clear_inputs();
        reset_n = 1;
        idle(2);
    endtask

    task automatic test_starve();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            clear_inputs();
            pipe_v = 1; ptw_v = 1;
            #1;
            total++; if (pipe_yumi !== (c != 8))
                $display("FAIL starve_pipe_c%0d got %b want %b", c, pipe_yumi, (c != 8)); else passed++;
            total++; if (ptw_yumi !== (c == 8))
                $display("FAIL starve_ptw_c%0d got %b want %b", c, ptw_yumi, (c == 8)); else passed++;
            total++; if (dc_v !== 1'b1)
                $display("FAIL starve_dcv_c%0d got %b want 1", c, dc_v); else passed++;
        end
        idle(3);
    endtask

    task automatic test_lock();
        // t0: pipe granted
        @(negedge clk); clear_inputs(); pipe_v = 1; #1;
        total++; if (pipe_yumi !== 1'b1) $display("FAIL lock_t0_pipe_yumi got %b want 1", pipe_yumi); else passed++;
        // t1: lock requested, pipe must be held off
        @(negedge clk); clear_inputs(); pipe_v = 1; lock_i = 1; #1;
        total++; if (pipe_yumi !== 1'b0) $display("FAIL lock_t1_pipe_yumi got %b want 0", pipe_yumi); else passed++;
        total++; if (lock_o !== 1'b0) $display("FAIL lock_t1_lock_o got %b want 0", lock_o); else passed++;
        // t2: draining
        @(negedge clk); clear_inputs(); pipe_v = 1; lock_i = 1; #1;
        total++; if (lock_o !== 1'b0) $display("FAIL lock_t2_lock_o got %b want 0", lock_o); else passed++;
        total++; if (pipe_yumi !== 1'b0) $display("FAIL lock_t2_pipe_yumi got %b want 0", pipe_yumi); else passed++;
        // t3: locked, PTW served
        @(negedge clk); clear_inputs(); pipe_v = 1; ptw_v = 1; lock_i = 1; #1;
        total++; if (lock_o !== 1'b1) $display("FAIL lock_t3_lock_o got %b want 1", lock_o); else passed++;
        total++; if (pipe_yumi !== 1'b0) $display("FAIL lock_t3_pipe_yumi got %b want 0", pipe_yumi); else passed++;
        total++; if (ptw_yumi !== 1'b1) $display("FAIL lock_t3_ptw_yumi got %b want 1", ptw_yumi); else passed++;
        // t4: done and lock together, done wins
        @(negedge clk); clear_inputs(); pipe_v = 1; lock_i = 1; done_i = 1; #1;
        total++; if (lock_o !== 1'b1) $display("FAIL lock_t4_lock_o got %b want 1", lock_o); else passed++;
        total++; if (pipe_yumi !== 1'b0) $display("FAIL lock_t4_pipe_yumi got %b want 0", pipe_yumi); else passed++;
        // t5: back to FREE
        @(negedge clk); clear_inputs(); pipe_v = 1; #1;
        total++; if (lock_o !== 1'b0) $display("FAIL lock_t5_lock_o got %b want 0", lock_o); else passed++;
        total++; if (pipe_yumi !== 1'b1) $display("FAIL lock_t5_pipe_yumi got %b want 1", pipe_yumi); else passed++;
        idle(3);
    endtask

    task automatic test_early_route();
        @(negedge clk); clear_inputs(); ptw_v = 1; #1;
        total++; if (ptw_yumi !== 1'b1) $display("FAIL early_t0_ptw_yumi got %b want 1", ptw_yumi); else passed++;
        @(negedge clk); clear_inputs(); pipe_v = 1; ptw_ptag_v = 1; #1;
        total++; if (pipe_yumi !== 1'b1) $display("FAIL early_t1_pipe_yumi got %b want 1", pipe_yumi); else passed++;
        total++; if (dc_ptag !== 28'h123_4567) $display("FAIL early_t1_ptag got %h want 1234567", dc_ptag); else passed++;
        total++; if (dc_ptag_v !== 1'b1) $display("FAIL early_t1_ptag_v got %b want 1", dc_ptag_v); else passed++;
        @(negedge clk); clear_inputs(); early = 1; pipe_ptag_v = 1; #1;
        total++; if ({ptw_early, pipe_early} !== 2'b10)
            $display("FAIL early_t2 got ptw/pipe=%b want 10", {ptw_early, pipe_early}); else passed++;
        total++; if (dc_ptag !== 28'h0AB_CDEF) $display("FAIL early_t2_ptag got %h want 0abcdef", dc_ptag); else passed++;
        @(negedge clk); clear_inputs(); early = 1; #1;
        total++; if ({ptw_early, pipe_early} !== 2'b01)
            $display("FAIL early_t3 got ptw/pipe=%b want 01", {ptw_early, pipe_early}); else passed++;
        @(negedge clk); clear_inputs(); early = 1; #1;
        total++; if ({ptw_early, pipe_early} !== 2'b00)
            $display("FAIL early_t4 got ptw/pipe=%b want 00", {ptw_early, pipe_early}); else passed++;
        idle(3);
    endtask

    task automatic test_flush();
        @(negedge clk); clear_inputs(); pipe_v = 1; #1;
        @(negedge clk); clear_inputs(); pipe_v = 1; #1;
        total++; if (pipe_yumi !== 1'b1) $display("FAIL flush_pre_pipe_yumi got %b want 1", pipe_yumi); else passed++;
        @(negedge clk); clear_inputs(); pipe_v = 1; ptw_v = 1; flush = 1; early = 1; pipe_ptag_v = 1; #1;
        total++; if (pipe_yumi !== 1'b0) $display("FAIL flush_pipe_yumi got %b want 0", pipe_yumi); else passed++;
        total++; if (ptw_yumi !== 1'b1) $display("FAIL flush_ptw_yumi got %b want 1", ptw_yumi); else passed++;
        total++; if (pipe_early !== 1'b0) $display("FAIL flush_t0_pipe_early got %b want 0", pipe_early); else passed++;
        total++; if (dc_ptag_v !== 1'b0) $display("FAIL flush_t0_ptag_v got %b want 0", dc_ptag_v); else passed++;
        @(negedge clk); clear_inputs(); early = 1; ptw_ptag_v = 1; #1;
        total++; if ({ptw_early, pipe_early} !== 2'b00)
            $display("FAIL flush_t1 got ptw/pipe=%b want 00", {ptw_early, pipe_early}); else passed++;
        total++; if (dc_ptag_v !== 1'b1) $display("FAIL flush_t1_ptag_v got %b want 1", dc_ptag_v); else passed++;
        @(negedge clk); clear_inputs(); early = 1; #1;
        total++; if ({ptw_early, pipe_early} !== 2'b10)
            $display("FAIL flush_t2 got ptw/pipe=%b want 10", {ptw_early, pipe_early}); else passed++;
        idle(3);
    endtask

    task automatic test_not_ready();
        @(negedge clk); clear_inputs(); pipe_v = 1; ready = 0; #1;
        total++; if ({pipe_yumi, dc_v} !== 2'b00)
            $display("FAIL nrdy_pipe got yumi/v=%b want 00", {pipe_yumi, dc_v}); else passed++;
        @(negedge clk); clear_inputs(); ptw_v = 1; ready = 0; #1;
        total++; if (ptw_yumi !== 1'b0) $display("FAIL nrdy_ptw_yumi got %b want 0", ptw_yumi); else passed++;
        @(negedge clk); clear_inputs(); ptw_v = 1; #1;
        total++; if (ptw_yumi !== 1'b1) $display("FAIL rdy_ptw_yumi got %b want 1", ptw_yumi); else passed++;
        total++; if (dc_pkt !== 64'h5555_0000_0000_0002)
            $display("FAIL rdy_ptw_pkt got %h want 5555000000000002", dc_pkt); else passed++;
        idle(3);
    endtask

    task automatic test_reset_mid_lock();
        @(negedge clk); clear_inputs(); lock_i = 1; #1;
        total++; if (lock_o !== 1'b0) $display("FAIL mlk_c0_lock_o got %b want 0", lock_o); else passed++;
        @(negedge clk); clear_inputs(); lock_i = 1; ptw_v = 1; #1;
        total++; if (lock_o !== 1'b1) $display("FAIL mlk_c1_lock_o got %b want 1", lock_o); else passed++;
        total++; if (ptw_yumi !== 1'b1) $display("FAIL mlk_c1_ptw_yumi got %b want 1", ptw_yumi); else passed++;
        @(negedge clk); clear_inputs(); lock_i = 1; ptw_v = 1; #1;
        @(negedge clk); clear_inputs(); lock_i = 1; ptw_v = 1; early = 1; ptw_ptag_v = 1; #1;
        total++; if (ptw_early !== 1'b1) $display("FAIL mlk_pre_ptw_early got %b want 1", ptw_early); else passed++;
        reset_n = 0;
        #1;
        total++; if ({lock_o, ptw_yumi, dc_v, ptw_early, pipe_early, dc_ptag_v} !== 6'b0)
            $display("FAIL mlk_rst_outputs got %b want 000000",
                     {lock_o, ptw_yumi, dc_v, ptw_early, pipe_early, dc_ptag_v}); else passed++;
        @(negedge clk); #1;
        total++; if ({lock_o, dc_v} !== 2'b00)
            $display("FAIL mlk_rst_hold got lock/v=%b want 00", {lock_o, dc_v}); else passed++;
        @(negedge clk); clear_inputs(); reset_n = 1; #1;
        @(negedge clk); clear_inputs(); pipe_v = 1; #1;
        total++; if (lock_o !== 1'b0) $display("FAIL mlk_post_lock_o got %b want 0", lock_o); else passed++;
        total++; if (pipe_yumi !== 1'b1) $display("FAIL mlk_post_pipe_yumi got %b want 1", pipe_yumi); else passed++;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_starve();
        test_lock();
        test_early_route();
        test_flush();
        test_not_ready();
        test_reset_mid_lock();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
